// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - opcode fields and shared constants for the load/store and byte-I/O unit
package mem_io_pkg;

  localparam logic [2:0] OPC_MEM  = 3'b111;
  localparam logic [2:0] OPC_IO   = 3'b011;
  localparam int         DIR_BIT  = 3;
  localparam int         TAG_NONE = 0;

  // Sign-extend the 16-bit immediate to the 32-bit operand width
  function automatic logic [31:0] sext_imm(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mem_io_fifo.sv
// rtl/mem_io_fifo.sv - synchronous FIFO with occupancy count, no empty bypass
module mem_io_fifo
  import mem_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = cnt_q;

  // A full FIFO refuses pushes even when popped in the same cycle
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and count registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: head is masked while empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_io_unit.sv
// rtl/mem_io_unit.sv - pipelined load/store plus FIFO-buffered byte I/O; MEM_IO_STAT_EN adds counters
module mem_io_unit
  import mem_io_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int TAG_W    = 6,
  parameter int MEM_LAT  = 2,
  parameter int IO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        ope,
  input  logic [31:0]       ds_val,
  input  logic [31:0]       dt_val,
  input  logic [TAG_W-1:0]  dd,
  input  logic [15:0]       imm,
  output logic              is_busy,
  output logic [TAG_W-1:0]  mem_addr,
  output logic [31:0]       mem_dd_val,
  output logic [TAG_W-1:0]  io_addr,
  output logic [31:0]       io_dd_val,
  output logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       d_wdata,
  input  logic [31:0]       d_rdata,
  output logic              d_en,
  output logic              d_we,
  input  logic [7:0]        io_in_data,
  input  logic              io_in_vld,
  output logic              io_in_rdy,
  output logic [7:0]        io_out_data,
  output logic              io_out_vld,
  input  logic              io_out_rdy
`ifdef MEM_IO_STAT_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_io_stall
`endif
);

  localparam int CNT_W = $clog2(IO_DEPTH) + 1;

  logic              is_mem, is_io, is_ld, in_req, out_req, busy;
  logic [31:0]       addr_sum;
  logic              in_push, in_pop, in_full, in_empty;
  logic [7:0]        in_head;
  logic [CNT_W-1:0]  in_count, in_cnt_nxt;
  logic              out_push, out_pop, out_full, out_empty;
  logic [CNT_W-1:0]  out_count;

  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [31:0]       d_wdata_q, d_wdata_d;
  logic              d_we_q, d_we_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [TAG_W-1:0]  chain_q [MEM_LAT];
  logic [TAG_W-1:0]  chain_d [MEM_LAT];
  logic [TAG_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]       mem_dd_val_q, mem_dd_val_d;
  logic [TAG_W-1:0]  io_addr_q, io_addr_d;
  logic [31:0]       io_dd_val_q, io_dd_val_d;
  logic              io_in_rdy_q, io_in_rdy_d;

  logic              unused_ok;
  assign unused_ok = ^{ope[5:4], addr_sum[31:ADDR_W], out_count};

  // Opcode decode and the combinational stall decision
  always_comb begin
    is_mem   = (ope[2:0] == OPC_MEM);
    is_io    = (ope[2:0] == OPC_IO);
    is_ld    = ope[DIR_BIT];
    in_req   = is_io && is_ld;
    out_req  = is_io && !is_ld;
    busy     = (in_req && in_empty) || (out_req && out_full);
    addr_sum = ds_val + sext_imm(imm);
  end

  // FIFO handshakes; io_in_rdy is registered so it implies not-full
  always_comb begin
    in_push    = io_in_vld && io_in_rdy_q;
    in_pop     = in_req && !busy;
    out_push   = out_req && !busy;
    out_pop    = io_out_vld && io_out_rdy;
    in_cnt_nxt = in_count + CNT_W'(in_push) - CNT_W'(in_pop);
  end

  mem_io_fifo #(.WIDTH(8), .DEPTH(IO_DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_push),
    .push_data (io_in_data),
    .pop       (in_pop),
    .full      (in_full),
    .empty     (in_empty),
    .head      (in_head),
    .count     (in_count)
  );

  mem_io_fifo #(.WIDTH(8), .DEPTH(IO_DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_push),
    .push_data (ds_val[7:0]),
    .pop       (out_pop),
    .full      (out_full),
    .empty     (out_empty),
    .head      (io_out_data),
    .count     (out_count)
  );

  // Next state: RAM request stage, load tag chain, and both writeback ports
  always_comb begin
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_we_d    = 1'b0;
    s1_tag_d  = TAG_W'(TAG_NONE);
    if (is_mem) begin
      d_addr_d  = addr_sum[ADDR_W-1:0];
      d_wdata_d = dt_val;
      d_we_d    = !is_ld;
      if (is_ld) begin
        s1_tag_d = dd;
      end
    end
    chain_d[0] = s1_tag_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      chain_d[i] = chain_q[i-1];
    end
    mem_addr_d   = chain_q[MEM_LAT-1];
    mem_dd_val_d = (chain_q[MEM_LAT-1] != TAG_W'(TAG_NONE)) ? d_rdata : 32'd0;
    io_addr_d    = TAG_W'(TAG_NONE);
    io_dd_val_d  = 32'd0;
    if (in_pop) begin
      io_addr_d   = dd;
      io_dd_val_d = {24'd0, in_head};
    end
    io_in_rdy_d = (in_cnt_nxt != CNT_W'(IO_DEPTH));
  end

  // Pipeline registers; reset discards any in-flight load tags
  always_ff @(posedge clk) begin
    if (rst) begin
      d_addr_q     <= '0;
      d_wdata_q    <= '0;
      d_we_q       <= 1'b0;
      s1_tag_q     <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        chain_q[i] <= '0;
      end
      mem_addr_q   <= '0;
      mem_dd_val_q <= '0;
      io_addr_q    <= '0;
      io_dd_val_q  <= '0;
      io_in_rdy_q  <= 1'b0;
    end else begin
      d_addr_q     <= d_addr_d;
      d_wdata_q    <= d_wdata_d;
      d_we_q       <= d_we_d;
      s1_tag_q     <= s1_tag_d;
      chain_q      <= chain_d;
      mem_addr_q   <= mem_addr_d;
      mem_dd_val_q <= mem_dd_val_d;
      io_addr_q    <= io_addr_d;
      io_dd_val_q  <= io_dd_val_d;
      io_in_rdy_q  <= io_in_rdy_d;
    end
  end

  assign is_busy    = busy;
  assign mem_addr   = mem_addr_q;
  assign mem_dd_val = mem_dd_val_q;
  assign io_addr    = io_addr_q;
  assign io_dd_val  = io_dd_val_q;
  assign d_addr     = d_addr_q;
  assign d_wdata    = d_wdata_q;
  assign d_we       = d_we_q;
  assign d_en       = 1'b1;
  assign io_in_rdy  = io_in_rdy_q;
  assign io_out_vld = !out_empty;

`ifdef MEM_IO_STAT_EN
  logic [31:0] stat_loads_q, stat_loads_d;
  logic [31:0] stat_stores_q, stat_stores_d;
  logic [31:0] stat_io_stall_q, stat_io_stall_d;

  // Event counters wrap at 2^32
  always_comb begin
    stat_loads_d    = stat_loads_q + 32'(is_mem && is_ld);
    stat_stores_d   = stat_stores_q + 32'(is_mem && !is_ld);
    stat_io_stall_d = stat_io_stall_q + 32'(busy);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_q    <= '0;
      stat_stores_q   <= '0;
      stat_io_stall_q <= '0;
    end else begin
      stat_loads_q    <= stat_loads_d;
      stat_stores_q   <= stat_stores_d;
      stat_io_stall_q <= stat_io_stall_d;
    end
  end

  assign stat_loads    = stat_loads_q;
  assign stat_stores   = stat_stores_q;
  assign stat_io_stall = stat_io_stall_q;
`endif

endmodule
